div_unit_p: RTL and testbench
=============================

Name: div_unit_p

Overview:
Parametrised multi-cycle radix-2 restoring divider for the OpenMIPS EX stage. It is the successor to the fixed 32-bit div block and adds:
- configurable operand width;
- a working annul path (a squashed DIV/DIVU aborts cleanly);
- an optional early-out when |dividend| < |divisor|;
- a busy indication that EX uses to build stallreq.

The result is packed {remainder, quotient} and written to HI/LO by the existing EX/MEM path.

Parameters:
- WIDTH, 32, operand width in bits (>= 4); result is 2*WIDTH.
- EARLY_OUT, 1, when 1, finish in one cycle if |dividend| < |divisor|.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high (rst=1 sampled at posedge clk resets the block).
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  start request; held high by EX until ready_o is seen.
- annul_i  in  1  abort current division (branch or exception flush).
- result_o  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- ready_o  out  1  result valid.
- busy_o  out  1  division in progress.

Behaviour:
Reset:
- State goes to FREE; cnt=0.
- result_o=0, ready_o=0, busy_o=0 on the edge after rst is sampled, whatever state was active (reset mid-operation included).

States: FREE, BYZERO, ON, END. Outputs are registered. ready_o=1 only in END. busy_o=1 only in BYZERO and ON. result_o=0 outside END.

FREE:
- start_i=1 and annul_i=0, with opdata2_i==0: go to BYZERO.
- Else if EARLY_OUT=1 and |op1| < |op2| (magnitudes per signed_div_i): go to END with quotient=0, remainder=opdata1_i unmodified.
- Else: latch signed_div_i, the operand signs and the absolute operand values, clear cnt, go to ON.
- start_i=0, or start_i=1 with annul_i=1: stay in FREE.

BYZERO:
- Next edge goes to END with result=0.

ON:
- One restoring step per edge, MSB first: shift the partial remainder, trial-subtract the divisor, and set the quotient bit if the result is non-negative. cnt increments.
- On the edge after cnt reaches WIDTH (the WIDTH+1th ON edge), apply sign correction and go to END.
- Sign correction, when signed:
  - quotient is negated iff the operand signs differ;
  - remainder takes the dividend's sign.
- The most-negative dividend divided by -1 gives quotient=most-negative (wraps) and remainder=0. No trap.
- Operand or start_i changes during ON are ignored, because operands are latched.
- annul_i=1 during ON: go to FREE on the next edge. ready_o never pulses and result_o stays 0. annul_i has priority over the final step.

END:
- ready_o=1 and result_o is held.
- Stay in END while start_i=1.
- start_i=0: go to FREE on the next edge, and ready_o/result_o return to 0.
- annul_i is ignored in END.

Latency, counted in edges from the edge that samples start_i in FREE to ready_o=1:
- normal division: WIDTH+2;
- divide by zero: 2;
- early-out: 1.

Back-to-back operation:
- The minimum gap is one FREE cycle.
- A new start is accepted only in FREE.

Test Plan:
- WIDTH=32, signed, -7/2: result_o = {0xFFFFFFFF, 0xFFFFFFFD}; ready_o rises on edge 34; busy_o high on edges 1–33.
- WIDTH=32, unsigned, 100/7 with EARLY_OUT=0: quotient=14, remainder=2, ready_o on edge 34. Deassert start_i: ready_o=0 and result_o=0 one edge later.
- Divide by zero, 0x1234/0: ready_o on edge 2 with result_o=0. Early-out (EARLY_OUT=1), unsigned 3/10: ready_o on edge 1 with quotient=0, remainder=3.
- annul_i pulsed on edge 10 of an ON sequence: FREE on edge 11, ready_o never asserts. An immediate new start of 50/5 completes with quotient=10, remainder=0.
- WIDTH=8 instance, signed -128/-1: quotient=0x80, remainder=0x00, ready_o on edge 10. Also signed 7/-2: quotient=0xFD, remainder=0x01.
- rst asserted mid-ON (edge 5) and mid-END: all outputs 0 and state FREE on the next edge. A subsequent division completes correctly.

Source files
------------

// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// The EX stage drives the operands and start/annul; the divider returns the result, ready and busy.
interface div_if #(
    parameter int WIDTH = 32
);
    logic               signed_div_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               start_i;
    logic               annul_i;
    logic [2*WIDTH-1:0] result_o;
    logic               ready_o;
    logic               busy_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o,
        input  busy_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o,
        output busy_o
    );
endinterface

// File: rtl/div_unit_p.sv
// Parametrised radix-2 restoring divider for the EX stage.
// The result is packed as {remainder, quotient}. The divider can be annulled, can finish early, and reports busy.
module div_unit_p #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic   clk,
    input  logic   rst,
    div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] dvs;
    logic             sgn1;
    logic             sgn2;

    logic             neg1;
    logic             neg2;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Operand magnitudes are taken straight from the bus, so they are ready in FREE.
    always_comb begin
        neg1 = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        neg2 = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        abs1 = neg1 ? -bus.opdata1_i : bus.opdata1_i;
        abs2 = neg2 ? -bus.opdata2_i : bus.opdata2_i;
    end

    // One restoring step: bring down the next dividend bit and trial-subtract.
    always_comb begin
        rem_sh = {rem, dq[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs};
        q_bit  = ~trial[WIDTH];
    end

    // The sign flags are latched already masked by signed_div_i.
    always_comb begin
        q_fix = (sgn1 ^ sgn2) ? -dq : dq;
        r_fix = sgn1 ? -rem : rem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FREE;
            cnt          <= '0;
            rem          <= '0;
            dq           <= '0;
            dvs          <= '0;
            sgn1         <= 1'b0;
            sgn2         <= 1'b0;
            bus.result_o <= '0;
            bus.ready_o  <= 1'b0;
            bus.busy_o   <= 1'b0;
        end else begin
            unique case (state)
                FREE: begin
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                    if (bus.start_i && !bus.annul_i) begin
                        if (bus.opdata2_i == '0) begin
                            state      <= BYZERO;
                            bus.busy_o <= 1'b1;
                        end else if (EARLY_OUT && (abs1 < abs2)) begin
                            state        <= END;
                            bus.ready_o  <= 1'b1;
                            bus.result_o <= {bus.opdata1_i, {WIDTH{1'b0}}};
                        end else begin
                            state      <= ON;
                            bus.busy_o <= 1'b1;
                            cnt        <= '0;
                            rem        <= '0;
                            dq         <= abs1;
                            dvs        <= abs2;
                            sgn1       <= neg1;
                            sgn2       <= neg2;
                        end
                    end
                end
                BYZERO: begin
                    state        <= END;
                    bus.busy_o   <= 1'b0;
                    bus.ready_o  <= 1'b1;
                    bus.result_o <= '0;
                end
                ON: begin
                    if (bus.annul_i) begin
                        state      <= FREE;
                        bus.busy_o <= 1'b0;
                        cnt        <= '0;
                    end else if (cnt == CW'(WIDTH)) begin
                        state        <= END;
                        bus.busy_o   <= 1'b0;
                        bus.ready_o  <= 1'b1;
                        bus.result_o <= {r_fix, q_fix};
                        cnt          <= '0;
                    end else begin
                        rem <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        dq  <= {dq[WIDTH-2:0], q_bit};
                        cnt <= cnt + CW'(1);
                    end
                end
                END: begin
                    if (!bus.start_i) begin
                        state        <= FREE;
                        bus.ready_o  <= 1'b0;
                        bus.result_o <= '0;
                    end
                end
                default: begin
                    state        <= FREE;
                    bus.busy_o   <= 1'b0;
                    bus.ready_o  <= 1'b0;
                    bus.result_o <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit_p.sv
// Directed bench for div_unit_p.
// It drives two 32-bit instances (one with early-out, one without) and one 8-bit instance.
module tb_div_unit_p;
    logic        clk = 1'b0;
    logic        rst;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic        st;
    logic        an;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    div_if #(.WIDTH(32)) if_a ();
    div_if #(.WIDTH(32)) if_b ();
    div_if #(.WIDTH(8))  if_c ();

    assign if_a.signed_div_i = sg;
    assign if_a.opdata1_i    = a;
    assign if_a.opdata2_i    = b;
    assign if_a.start_i      = st;
    assign if_a.annul_i      = an;
    assign if_b.signed_div_i = sg;
    assign if_b.opdata1_i    = a;
    assign if_b.opdata2_i    = b;
    assign if_b.start_i      = st;
    assign if_b.annul_i      = an;

    div_unit_p #(.WIDTH(32), .EARLY_OUT(1'b1)) u_a (
        .clk(clk), .rst(rst), .bus(if_a.slave));
    div_unit_p #(.WIDTH(32), .EARLY_OUT(1'b0)) u_b (
        .clk(clk), .rst(rst), .bus(if_b.slave));
    div_unit_p #(.WIDTH(8), .EARLY_OUT(1'b1)) u_c (
        .clk(clk), .rst(rst), .bus(if_c.slave));

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Count edges until the selected instance is ready; n == lim means it timed out.
    task automatic wait_ready(input int sel, input int lim,
                              output int n, output int bad);
        logic r;
        logic bz;
        n   = 0;
        bad = 0;
        do begin
            step();
            n++;
            case (sel)
                0:       begin r = if_a.ready_o; bz = if_a.busy_o; end
                1:       begin r = if_b.ready_o; bz = if_b.busy_o; end
                default: begin r = if_c.ready_o; bz = if_c.busy_o; end
            endcase
            if (!r && !bz) bad++;
        end while (!r && n < lim);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({if_a.ready_o, if_a.busy_o, if_a.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0",
                     {if_a.ready_o, if_a.busy_o, if_a.result_o});
        end
        checks++;
        if ({if_b.ready_o, if_b.busy_o, if_b.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0",
                     {if_b.ready_o, if_b.busy_o, if_b.result_o});
        end
        checks++;
        if ({if_c.ready_o, if_c.busy_o, if_c.result_o} !== 18'd0) begin
            errors++;
            $display("FAIL reset_c got %h exp 0",
                     {if_c.ready_o, if_c.busy_o, if_c.result_o});
        end
    endtask

    task automatic test_signed();
        int n;
        int bad;
        sg = 1'b1; a = -32'sd7; b = 32'd2; st = 1'b1;
        wait_ready(0, 60, n, bad);
        checks++;
        if (n !== 34) begin
            errors++; $display("FAIL sdiv_lat got %0d exp 34", n);
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL sdiv_busy got %0d idle exp 0", bad);
        end
        checks++;
        if (if_a.result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
            errors++;
            $display("FAIL sdiv_res got %h exp ffffffff_fffffffd", if_a.result_o);
        end
        checks++;
        if ({if_b.ready_o, if_b.result_o} !== {1'b1, 64'hFFFFFFFF_FFFFFFFD}) begin
            errors++;
            $display("FAIL sdiv_res_b got %h", {if_b.ready_o, if_b.result_o});
        end
        step();
        checks++;
        if ({if_a.ready_o, if_a.result_o} !== {1'b1, 64'hFFFFFFFF_FFFFFFFD}) begin
            errors++;
            $display("FAIL sdiv_hold got %h", {if_a.ready_o, if_a.result_o});
        end
        st = 1'b0;
        step();
        checks++;
        if ({if_a.ready_o, if_a.result_o, if_b.ready_o, if_b.result_o} !== 130'd0) begin
            errors++;
            $display("FAIL sdiv_drop got %b/%h exp 0", if_a.ready_o, if_a.result_o);
        end
    endtask

    task automatic test_unsigned();
        int n;
        int bad;
        sg = 1'b0; a = 32'd100; b = 32'd7; st = 1'b1;
        repeat (3) step();
        a = 32'd5; b = 32'd1;
        wait_ready(1, 60, n, bad);
        checks++;
        if (n + 3 !== 34) begin
            errors++; $display("FAIL udiv_lat got %0d exp 34", n + 3);
        end
        checks++;
        if (if_b.result_o !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL udiv_res got %h exp 2_14", if_b.result_o);
        end
        st = 1'b0;
        step();
        checks++;
        if ({if_b.ready_o, if_b.result_o} !== 65'd0) begin
            errors++;
            $display("FAIL udiv_drop got %h exp 0", {if_b.ready_o, if_b.result_o});
        end
    endtask

    task automatic test_byzero();
        int n;
        int bad;
        sg = 1'b0; a = 32'h1234; b = 32'd0; st = 1'b1;
        wait_ready(0, 10, n, bad);
        checks++;
        if (n !== 2 || bad !== 0) begin
            errors++;
            $display("FAIL byzero_lat got %0d/%0d exp 2/0", n, bad);
        end
        checks++;
        if (if_a.result_o !== 64'd0) begin
            errors++; $display("FAIL byzero_res got %h exp 0", if_a.result_o);
        end
        st = 1'b0;
        step();
    endtask

    task automatic test_early_out();
        logic [31:0] dv [2];
        logic [63:0] ex [2];
        int n;
        int n2;
        int bad;
        dv[0] = 32'd3;     ex[0] = {32'd3, 32'd0};
        dv[1] = -32'sd3;   ex[1] = {32'hFFFFFFFD, 32'd0};
        for (int i = 0; i < 2; i++) begin
            sg = (i == 1); a = dv[i]; b = 32'd10; st = 1'b1;
            wait_ready(0, 60, n, bad);
            checks++;
            if (n !== 1 || if_a.result_o !== ex[i]) begin
                errors++;
                $display("FAIL early%0d got %0d/%h exp 1/%h", i, n, if_a.result_o, ex[i]);
            end
            checks++;
            if ({if_b.busy_o, if_b.ready_o} !== 2'b10) begin
                errors++;
                $display("FAIL noearly%0d_busy got %b exp 10", i, {if_b.busy_o, if_b.ready_o});
            end
            wait_ready(1, 60, n2, bad);
            checks++;
            if (n + n2 !== 34 || if_b.result_o !== ex[i]) begin
                errors++;
                $display("FAIL noearly%0d got %0d/%h exp 34/%h", i, n + n2, if_b.result_o, ex[i]);
            end
            st = 1'b0;
            step();
        end
    endtask

    task automatic test_annul();
        int n;
        int bad;
        sg = 1'b0; a = 32'd1000; b = 32'd3; st = 1'b1;
        repeat (10) step();
        an = 1'b1;
        step();
        checks++;
        if ({if_a.busy_o, if_a.ready_o, if_a.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL annul_a got %h exp 0", {if_a.busy_o, if_a.ready_o, if_a.result_o});
        end
        checks++;
        if ({if_b.busy_o, if_b.ready_o, if_b.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL annul_b got %h exp 0", {if_b.busy_o, if_b.ready_o, if_b.result_o});
        end
        an = 1'b0; a = 32'd50; b = 32'd5;
        wait_ready(0, 60, n, bad);
        checks++;
        if (n !== 34 || if_a.result_o !== {32'd0, 32'd10}) begin
            errors++;
            $display("FAIL annul_next got %0d/%h exp 34/0_a", n, if_a.result_o);
        end
        st = 1'b0;
        step();
    endtask

    task automatic test_w8();
        logic [7:0]  x [3];
        logic [7:0]  y [3];
        logic [15:0] ex [3];
        int n;
        int bad;
        x[0] = 8'h80; y[0] = 8'hFF; ex[0] = 16'h0080;
        x[1] = 8'h07; y[1] = 8'hFE; ex[1] = 16'h01FD;
        x[2] = 8'hFB; y[2] = 8'h05; ex[2] = 16'h00FF;
        for (int i = 0; i < 3; i++) begin
            if_c.signed_div_i = 1'b1;
            if_c.opdata1_i = x[i];
            if_c.opdata2_i = y[i];
            if_c.start_i = 1'b1;
            wait_ready(2, 30, n, bad);
            checks++;
            if (n !== 10 || if_c.result_o !== ex[i]) begin
                errors++;
                $display("FAIL w8_%0d got %0d/%h exp 10/%h", i, n, if_c.result_o, ex[i]);
            end
            if_c.start_i = 1'b0;
            step();
        end
    endtask

    task automatic test_reset_mid();
        int n;
        int bad;
        sg = 1'b0; a = 32'd1000; b = 32'd3; st = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        step();
        checks++;
        if ({if_a.busy_o, if_a.ready_o, if_a.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL rst_on got %h exp 0", {if_a.busy_o, if_a.ready_o, if_a.result_o});
        end
        rst = 1'b0;
        wait_ready(0, 60, n, bad);
        checks++;
        if (n !== 34 || if_a.result_o !== {32'd1, 32'd333}) begin
            errors++;
            $display("FAIL rst_redo got %0d/%h exp 34/1_14d", n, if_a.result_o);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({if_a.busy_o, if_a.ready_o, if_a.result_o} !== 66'd0) begin
            errors++;
            $display("FAIL rst_end got %h exp 0", {if_a.busy_o, if_a.ready_o, if_a.result_o});
        end
        rst = 1'b0; st = 1'b0;
        step();
        a = 32'd100; b = 32'd7; st = 1'b1;
        wait_ready(0, 60, n, bad);
        checks++;
        if (n !== 34 || if_a.result_o !== {32'd2, 32'd14}) begin
            errors++;
            $display("FAIL rst_after got %0d/%h exp 34/2_e", n, if_a.result_o);
        end
        st = 1'b0;
        step();
    endtask

    initial begin
        rst = 1'b1; sg = 1'b0; a = '0; b = '0; st = 1'b0; an = 1'b0;
        if_c.signed_div_i = 1'b0;
        if_c.opdata1_i = '0;
        if_c.opdata2_i = '0;
        if_c.start_i = 1'b0;
        if_c.annul_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_signed();
        test_unsigned();
        test_byzero();
        test_early_out();
        test_annul();
        test_w8();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
